// File: rtl/fetch_pkg.sv
// Shared fetch-side constants and the queue entry layout.
package fetch_pkg;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] PC_LO    = 32'h0000_3000;
    localparam logic [31:0] PC_HI    = 32'h0000_6FFC;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } fq_entry_t;

endpackage

// File: rtl/pc_addr_check.sv
// Fetch/load address legality: word aligned and inside [PC_LO, PC_HI].
module pc_addr_check #(
    parameter logic [31:0] PC_LO = fetch_pkg::PC_LO,
    parameter logic [31:0] PC_HI = fetch_pkg::PC_HI
) (
    input  logic [31:0] pc,
    output logic        adel
);
    import fetch_pkg::*;

    assign adel = (pc[1:0] != 2'b00) || (pc < PC_LO) || (pc > PC_HI);

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue between the PC register and decode.
// push_ready gates the PC enable; flush drops all wrong-path entries.
module fetch_queue #(
    parameter int          DEPTH = 4,
    parameter logic [31:0] PC_LO = fetch_pkg::PC_LO,
    parameter logic [31:0] PC_HI = fetch_pkg::PC_HI,
    localparam int         PW    = $clog2(DEPTH),
    localparam int         CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_valid,
    input  logic [31:0]   push_pc,
    input  logic [31:0]   push_instr,
    output logic          push_ready,
    output logic          pop_valid,
    output logic [31:0]   pop_pc,
    output logic [31:0]   pop_instr,
    output logic          pop_adel,
    input  logic          pop_ready,
    input  logic          flush,
    output logic [CW-1:0] count
);
    import fetch_pkg::*;

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [PW-1:0] wr_ptr, rd_ptr;
    fq_entry_t     mem [DEPTH];
    fq_entry_t     head;
    logic          push_adel;
    logic          do_push, do_pop;

    pc_addr_check #(.PC_LO(PC_LO), .PC_HI(PC_HI)) u_chk (
        .pc   (push_pc),
        .adel (push_adel)
    );

    assign push_ready = (count != FULL);
    assign pop_valid  = (count != '0);
    assign do_push    = push_valid && push_ready && !flush;
    assign do_pop     = pop_valid && pop_ready && !flush;

    // Storage is deliberately left unreset; count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr].pc    <= push_pc;
            mem[wr_ptr].instr <= push_adel ? NOP : push_instr;
            mem[wr_ptr].adel  <= push_adel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head      = mem[rd_ptr];
    assign pop_pc    = pop_valid ? head.pc    : '0;
    assign pop_instr = pop_valid ? head.instr : '0;
    assign pop_adel  = pop_valid ? head.adel  : 1'b0;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: model entries queued on push, compared on pop.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        push_valid = 1'b0;
    logic [31:0] push_pc = '0;
    logic [31:0] push_instr = '0;
    logic        push_ready;
    logic        pop_valid;
    logic [31:0] pop_pc;
    logic [31:0] pop_instr;
    logic        pop_adel;
    logic        pop_ready = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    fq_entry_t   sb [$];
    logic [31:0] popped [$];

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .push_valid (push_valid),
        .push_pc    (push_pc),
        .push_instr (push_instr),
        .push_ready (push_ready),
        .pop_valid  (pop_valid),
        .pop_pc     (pop_pc),
        .pop_instr  (pop_instr),
        .pop_adel   (pop_adel),
        .pop_ready  (pop_ready),
        .flush      (flush),
        .count      (count)
    );

    always #5 clk = ~clk;

    function automatic fq_entry_t model(input logic [31:0] pc, input logic [31:0] instr);
        fq_entry_t e;
        e.pc    = pc;
        e.adel  = (pc[1:0] != 2'b00) || (pc < 32'h0000_3000) || (pc > 32'h0000_6FFC);
        e.instr = e.adel ? 32'h0 : instr;
        return e;
    endfunction

    // One clock: settle the model from the current inputs, compare any pop, advance, check state.
    task automatic step();
        bit do_push, do_pop;
        fq_entry_t exp_e;
        do_push = push_valid && (sb.size() != DEPTH);
        do_pop  = pop_ready && (sb.size() != 0);
        if (flush) begin
            sb.delete();
        end else begin
            if (do_pop) begin
                exp_e = sb.pop_front();
                popped.push_back(pop_pc);
                checks++;
                if ({pop_pc, pop_instr, pop_adel} !== {exp_e.pc, exp_e.instr, exp_e.adel}) begin
                    errors++;
                    $display("FAIL pop_entry: got %h/%h/%b expected %h/%h/%b",
                             pop_pc, pop_instr, pop_adel, exp_e.pc, exp_e.instr, exp_e.adel);
                end
            end
            if (do_push) sb.push_back(model(push_pc, push_instr));
        end
        @(posedge clk);
        #1;
        checks++;
        if ({count, push_ready, pop_valid} !==
            {3'(sb.size()), sb.size() != DEPTH, sb.size() != 0}) begin
            errors++;
            $display("FAIL occupancy: got count=%0d ready=%b valid=%b expected count=%0d",
                     count, push_ready, pop_valid, sb.size());
        end
        if (sb.size() == 0) begin
            checks++;
            if ({pop_pc, pop_instr, pop_adel} !== 65'h0) begin
                errors++;
                $display("FAIL empty_data: got %h/%h/%b expected zeros", pop_pc, pop_instr, pop_adel);
            end
        end
    endtask

    task automatic idle_inputs();
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic drain();
        idle_inputs();
        pop_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) step();
        pop_ready = 1'b0;
    endtask

    task automatic push_only(input logic [31:0] pc, input logic [31:0] instr);
        push_valid = 1'b1;
        push_pc    = pc;
        push_instr = instr;
        pop_ready  = 1'b0;
        step();
        push_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if ({push_ready, pop_valid, count, pop_pc, pop_instr, pop_adel} !== {1'b1, 1'b0, 3'd0, 65'h0}) begin
            errors++;
            $display("FAIL reset_state: got ready=%b valid=%b count=%0d pc=%h expected 1/0/0/0",
                     push_ready, pop_valid, count, pop_pc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_push();
        push_only(32'h3000, 32'h2401_0001);
        checks++;
        if ({pop_valid, pop_pc, count} !== {1'b1, 32'h3000, 3'd1}) begin
            errors++;
            $display("FAIL single_push: got valid=%b pc=%h count=%0d expected 1/00003000/1",
                     pop_valid, pop_pc, count);
        end
        drain();
    endtask

    task automatic test_fill_wrap();
        logic [31:0] exp_order [6];
        exp_order = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3010, 32'h3014};
        popped.delete();
        for (int i = 0; i < 4; i++) push_only(32'h3000 + 32'(4 * i), 32'h1000_0000 + 32'(i));
        checks++;
        if ({push_ready, count} !== {1'b0, 3'd4}) begin
            errors++;
            $display("FAIL full_ready: got ready=%b count=%0d expected 0/4", push_ready, count);
        end
        push_only(32'h3010, 32'hDEAD_BEEF);
        idle_inputs();
        pop_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        push_only(32'h3010, 32'h1000_0004);
        push_only(32'h3014, 32'h1000_0005);
        drain();
        checks++;
        if (popped.size() != 6) begin
            errors++;
            $display("FAIL wrap_count: got %0d pops expected 6", popped.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (popped[i] !== exp_order[i]) begin
                    errors++;
                    $display("FAIL wrap_order[%0d]: got %h expected %h", i, popped[i], exp_order[i]);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        push_only(32'h3100, 32'h1);
        push_only(32'h3104, 32'h2);
        push_valid = 1'b1;
        push_pc    = 32'h3108;
        push_instr = 32'h3;
        pop_ready  = 1'b1;
        step();
        checks++;
        if ({count, pop_pc} !== {3'd2, 32'h3104}) begin
            errors++;
            $display("FAIL push_pop_at2: got count=%0d head=%h expected 2/00003104", count, pop_pc);
        end
        push_only(32'h310C, 32'h4);
        push_only(32'h3110, 32'h5);
        push_valid = 1'b1;
        push_pc    = 32'h3114;
        push_instr = 32'h6;
        pop_ready  = 1'b1;
        step();
        checks++;
        if ({count, pop_pc} !== {3'd3, 32'h3108}) begin
            errors++;
            $display("FAIL push_pop_full: got count=%0d head=%h expected 3/00003108", count, pop_pc);
        end
        drain();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) push_only(32'h3200 + 32'(4 * i), 32'hA0 + 32'(i));
        push_valid = 1'b1;
        push_pc    = 32'h3020;
        push_instr = 32'hBAD0_0000;
        flush      = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if ({count, pop_valid, push_ready} !== {3'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL flush_state: got count=%0d valid=%b ready=%b expected 0/0/1",
                     count, pop_valid, push_ready);
        end
        push_only(32'h3040, 32'h0000_0040);
        checks++;
        if ({pop_valid, pop_pc} !== {1'b1, 32'h3040}) begin
            errors++;
            $display("FAIL flush_refill: got valid=%b head=%h expected 1/00003040", pop_valid, pop_pc);
        end
        // Flush of a full queue frees it for the next push immediately.
        for (int i = 0; i < 3; i++) push_only(32'h3044 + 32'(4 * i), 32'h1);
        pop_ready = 1'b1;
        flush     = 1'b1;
        step();
        idle_inputs();
        drain();
    endtask

    task automatic test_adel();
        push_only(32'h3002, 32'h8C01_0000);
        checks++;
        if ({pop_adel, pop_instr} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL adel_misalign: got adel=%b instr=%h expected 1/00000000", pop_adel, pop_instr);
        end
        push_valid = 1'b1;
        push_pc    = 32'h7000;
        push_instr = 32'h1234_5678;
        pop_ready  = 1'b1;
        step();
        checks++;
        if ({pop_adel, pop_instr} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL adel_high: got adel=%b instr=%h expected 1/00000000", pop_adel, pop_instr);
        end
        push_pc    = 32'h6FFC;
        push_instr = 32'hCAFE_F00D;
        step();
        checks++;
        if ({pop_adel, pop_instr} !== {1'b0, 32'hCAFE_F00D}) begin
            errors++;
            $display("FAIL adel_top_legal: got adel=%b instr=%h expected 0/cafef00d", pop_adel, pop_instr);
        end
        push_pc    = 32'h2FFC;
        push_instr = 32'h5;
        step();
        checks++;
        if (pop_adel !== 1'b1) begin
            errors++;
            $display("FAIL adel_low: got %b expected 1", pop_adel);
        end
        drain();
    endtask

    task automatic test_async_reset();
        push_only(32'h3300, 32'h11);
        push_only(32'h3304, 32'h22);
        #3;
        reset = 1'b1;
        #1;
        sb.delete();
        checks++;
        if ({pop_valid, count, push_ready, pop_pc} !== {1'b0, 3'd0, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL async_reset: got valid=%b count=%0d ready=%b pc=%h expected 0/0/1/0",
                     pop_valid, count, push_ready, pop_pc);
        end
        @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        push_only(32'h3400, 32'h33);
        checks++;
        if ({pop_valid, pop_pc, pop_instr} !== {1'b1, 32'h3400, 32'h33}) begin
            errors++;
            $display("FAIL post_reset_push: got valid=%b pc=%h instr=%h expected 1/00003400/00000033",
                     pop_valid, pop_pc, pop_instr);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill_wrap();
        test_simultaneous();
        test_flush();
        test_adel();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue directly downstream of the PC register. Each cycle the fetch side offers one {PC, instruction} pair; the queue buffers up to DEPTH pairs for the decode stage. It decouples decode stalls from fetch. `push_ready` drives the PC register's enable, so a full queue freezes the PC. A redirect flush discards all queued (wrong-path) instructions. Each entry is tagged with an address-error flag.

## Interface
- `DEPTH`, 4: number of entries; power of two, ≥2.
- `PC_RESET`, 32'h0000_3000: reset/boot PC; exported for the bench.
- `PC_LO`, 32'h0000_3000: lowest legal fetch address.
- `PC_HI`, 32'h0000_6FFC: highest legal fetch address.
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: asynchronous, active-high; clears all control state immediately.
- `push_valid` in 1: fetch offers a pair this cycle.
- `push_pc` in 32: PC of the offered instruction.
- `push_instr` in 32: instruction word from instruction memory.
- `push_ready` out 1: queue not full; connects to PC enable.
- `pop_valid` out 1: queue non-empty; head entry presented.
- `pop_pc` out 32: head entry PC.
- `pop_instr` out 32: head entry instruction; 32'h0 (nop) when `pop_adel` is set.
- `pop_adel` out 1: head entry address error.
- `pop_ready` in 1: decode accepts the head this cycle (not stalled).
- `flush` in 1: redirect; discard all entries.
- `count` out $clog2(DEPTH+1): current occupancy.

## Operation
- Circular buffer with `wr_ptr` and `rd_ptr`, each $clog2(DEPTH) bits, wrapping by natural overflow. Occupancy counter `count`.
- **Push:** fires when `push_valid && push_ready`. Writes {`push_pc`, `push_instr`, adel} at `wr_ptr`, then increments `wr_ptr`.
- **adel rule:** adel = (`push_pc[1:0] != 0`) or `push_pc < PC_LO` or `push_pc > PC_HI`. When adel is set, the stored instruction is forced to 32'h0.
- **Pop:** fires when `pop_valid && pop_ready`. Increments `rd_ptr`.
- **Count update:** +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- `push_ready = (count != DEPTH)`. It does not depend on `pop_ready`, so a full queue refuses a push even while a pop is in progress.
- `pop_valid = (count != 0)`.
- When empty, `pop_pc`, `pop_instr` and `pop_adel` are 0.
- **Flush:** has priority over push and pop. At the next edge, both pointers and `count` go to 0. A push or pop offered in the flush cycle has no effect.
- **Reset:** asynchronous; pointers = 0, `count` = 0. Storage array is not reset.

## Timing
- **Reset values:** `push_ready` = 1, `pop_valid` = 0, `count` = 0, `pop_pc`/`pop_instr`/`pop_adel` = 0.
- **Latency:** a push at edge N is visible at `pop_*` after edge N. There is no same-cycle bypass when empty; minimum latency is 1 cycle.
- **Throughput:** one push and one pop per cycle sustained when 0 < `count` < DEPTH.
- **Combinational paths:** `push_ready`, `pop_valid` and `count` depend only on registered state. `pop_*` data is a mux of storage at `rd_ptr`. No combinational path from any input to any output.
- **Flush with full queue:** the next cycle has `push_ready` = 1 and `pop_valid` = 0.
- **Reset mid-operation:** outputs return to reset values without waiting for a clock edge. The first push after reset release lands in entry 0.

## Structure
- **Shared package `fetch_pkg`:**
  - constants `PC_RESET`, `PC_LO`, `PC_HI`, `NOP` = 32'h0;
  - entry struct {pc[31:0], instr[31:0], adel}.
- **Sub-module `pc_addr_check`:** combinational; input pc, output adel. It is reused by the data-memory stage for its own address check.
- Everything else stays in `fetch_queue`.

## Test plan
- **Reset then single push:** push {0x3000, 0x24010001}, `pop_ready` = 0 → one edge later `pop_valid` = 1, `pop_pc` = 0x3000, `count` = 1.
- **Fill and wrap:** push PCs 0x3000–0x300C with `pop_ready` = 0 → `push_ready` = 0 at `count` = 4. A fifth push is ignored. Then pop 4 and push 2 more → popped order is 0x3000, 0x3004, 0x3008, 0x300C, 0x3010, 0x3014.
- **Simultaneous push and pop at `count` = 2:** `count` stays 2 and the head advances by one. With `count` = 4 and `pop_ready` = 1, the push is refused and `count` becomes 3.
- **Flush:** with 3 entries queued, assert `flush` while also pushing 0x3020 → next cycle `count` = 0, `pop_valid` = 0. The next push of 0x3040 is the head after one edge.
- **Address error:** push {0x3002, 0x8C010000} → `pop_adel` = 1, `pop_instr` = 0. Push {0x7000, x} → `pop_adel` = 1. Push {0x6FFC, x} → `pop_adel` = 0.
- **Asynchronous reset:** with 2 entries queued, assert `reset` between edges → `pop_valid` = 0 and `count` = 0 before the next posedge.
